// File: rtl/bus_ram_slave.sv
// Word RAM slave on the JTAG-master system bus: windowed decode, byte-enabled write bursts, read bursts with busyIN back-pressure.
// Optional BUS_RAM_WAIT_STATE_EN inserts one busyOUT cycle after every accepted write beat.
module bus_ram_slave #(
    parameter logic [31:0] BASE_ADDRESS    = 32'h4000_0000,
    parameter int          ADDR_WORDS_LOG2 = 10
) (
    input  logic        system_clock,
    input  logic        system_reset_n,
    input  logic [31:0] address_dataIN,
    input  logic [3:0]  byte_enableIN,
    input  logic [7:0]  burst_sizeIN,
    input  logic        read_n_writeIN,
    input  logic        begin_transactionIN,
    input  logic        end_transactionIN,
    input  logic        data_validIN,
    input  logic        busyIN,
    output logic [31:0] address_dataOUT,
    output logic        data_validOUT,
    output logic        end_transactionOUT,
    output logic        busyOUT,
    output logic        errorOUT
);
    localparam int AW    = ADDR_WORDS_LOG2;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_READ_END, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] index_q, index_d;
    logic [8:0]    count_q, count_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rdata_q;

    logic          select;
    logic [AW-1:0] req_index;
    logic [31:0]   last_index;
    logic          wr_accept;
    logic          rd_advance;
    logic          rd_fetch;

    assign req_index  = address_dataIN[AW+1:2];
    assign select     = begin_transactionIN &&
                        (address_dataIN[31:AW+2] == BASE_ADDRESS[31:AW+2]);
    assign last_index = 32'(req_index) + 32'(burst_sizeIN);

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q <= S_IDLE;
            index_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            count_q <= count_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        count_d    = count_q;
        valid_d    = valid_q;
        busy_d     = 1'b0;
        wr_accept  = 1'b0;
        rd_advance = 1'b0;
        rd_fetch   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (select) begin
                    index_d = req_index;
                    count_d = 9'(burst_sizeIN) + 9'd1;
                    if (last_index > 32'(DEPTH - 1))
                        state_d = S_ERROR;
                    else
                        state_d = read_n_writeIN ? S_READ : S_WRITE;
                end
            end
            S_WRITE: begin
                wr_accept = data_validIN && !busy_q && (count_q != 9'd0);
                if (wr_accept) begin
                    index_d = index_q + 1'b1;
                    count_d = count_q - 9'd1;
                end
`ifdef BUS_RAM_WAIT_STATE_EN
                busy_d = wr_accept;
`else
                busy_d = 1'b0;
`endif
                if (end_transactionIN) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_READ: begin
                // rdata_q is the presented beat; refill it whenever it is empty or being consumed
                rd_advance = !valid_q || !busyIN;
                rd_fetch   = rd_advance && (count_q != 9'd0);
                if (rd_fetch) begin
                    index_d = index_q + 1'b1;
                    count_d = count_q - 9'd1;
                    valid_d = 1'b1;
                end else if (rd_advance) begin
                    valid_d = 1'b0;
                end
                if (valid_q && !busyIN && (count_q == 9'd0))
                    state_d = S_READ_END;
                if (end_transactionIN) begin
                    state_d  = S_IDLE;
                    valid_d  = 1'b0;
                    rd_fetch = 1'b0;
                end
            end
            S_READ_END: state_d = S_IDLE;
            S_ERROR:    state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (wr_accept) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_enableIN[b])
                    mem[index_q][8*b +: 8] <= address_dataIN[8*b +: 8];
            end
        end
        if (rd_fetch)
            rdata_q <= mem[index_q];
    end

    // Wired-OR bus: every output is forced to 0 unless this slave is driving it
    always_comb begin
        address_dataOUT    = valid_q ? rdata_q : 32'd0;
        data_validOUT      = valid_q;
        end_transactionOUT = (state_q == S_READ_END) || (state_q == S_ERROR);
        errorOUT           = (state_q == S_ERROR);
        busyOUT            = (state_q == S_WRITE) && busy_q;
    end
endmodule

// File: tb/tb_bus_ram_slave.sv
// Bench for bus_ram_slave: directed bus transactions plus randomized write/readback checked against a word-array model.
module tb_bus_ram_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address_dataIN = '0;
    logic [3:0]  byte_enableIN = '0;
    logic [7:0]  burst_sizeIN = '0;
    logic        read_n_writeIN = 1'b0;
    logic        begin_transactionIN = 1'b0;
    logic        end_transactionIN = 1'b0;
    logic        data_validIN = 1'b0;
    logic        busyIN = 1'b0;
    logic [31:0] address_dataOUT;
    logic        data_validOUT;
    logic        end_transactionOUT;
    logic        busyOUT;
    logic        errorOUT;

    int tests = 0;
    int fails = 0;

    logic [31:0] ref_mem [1024];
    logic [31:0] wbuf [256];
    logic [31:0] exp_q [$];

    logic        hold_pending = 1'b0;
    logic [31:0] held_data = '0;

    bus_ram_slave dut (
        .system_clock        (clk),
        .system_reset_n      (rst_n),
        .address_dataIN      (address_dataIN),
        .byte_enableIN       (byte_enableIN),
        .burst_sizeIN        (burst_sizeIN),
        .read_n_writeIN      (read_n_writeIN),
        .begin_transactionIN (begin_transactionIN),
        .end_transactionIN   (end_transactionIN),
        .data_validIN        (data_validIN),
        .busyIN              (busyIN),
        .address_dataOUT     (address_dataOUT),
        .data_validOUT       (data_validOUT),
        .end_transactionOUT  (end_transactionOUT),
        .busyOUT             (busyOUT),
        .errorOUT            (errorOUT)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] all_outs();
        return {27'd0, data_validOUT, end_transactionOUT, busyOUT, errorOUT, 1'b0} | address_dataOUT;
    endfunction

    // Scoreboard monitor: every consumed read beat must match the head of exp_q
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending <= 1'b0;
        end else if (data_validOUT) begin
            if (hold_pending)
                check("stall_hold", address_dataOUT, held_data);
            if (busyIN) begin
                hold_pending <= 1'b1;
                held_data    <= address_dataOUT;
            end else begin
                hold_pending <= 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", address_dataOUT, 32'hxxxx_xxxx);
                end else begin
                    check("read_data", address_dataOUT, exp_q.pop_front());
                end
            end
        end else begin
            hold_pending <= 1'b0;
        end
    end

    task automatic start_txn(input logic [31:0] addr, input int burst, input logic rnw);
        @(posedge clk); #1;
        begin_transactionIN = 1'b1;
        address_dataIN      = addr;
        burst_sizeIN        = 8'(burst);
        read_n_writeIN      = rnw;
        data_validIN        = 1'b0;
        @(posedge clk); #1;
        begin_transactionIN = 1'b0;
        address_dataIN      = '0;
    endtask

    task automatic do_write(input logic [31:0] addr, input int nbeats, input logic [3:0] be_fixed,
                            input bit rand_be, input bit gaps, input bit check_ws);
        int base  = int'(addr[11:2]);
        int k     = 0;
        int cycle = 1;
        int guard = 0;
        int acc [$];
        start_txn(addr, nbeats - 1, 1'b0);
        while (k < nbeats && guard < 2000) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                data_validIN      = 1'b0;
                end_transactionIN = 1'b0;
            end else begin
                data_validIN      = 1'b1;
                address_dataIN    = wbuf[k];
                byte_enableIN     = rand_be ? 4'($urandom_range(0, 15)) : be_fixed;
                end_transactionIN = !busyOUT && (k == nbeats - 1);
                if (!busyOUT) begin
                    for (int b = 0; b < 4; b++)
                        if (byte_enableIN[b])
                            ref_mem[base + k][8*b +: 8] = wbuf[k][8*b +: 8];
                    acc.push_back(cycle);
                    k++;
                end
            end
            @(posedge clk); #1;
            cycle++;
            guard++;
        end
        data_validIN      = 1'b0;
        end_transactionIN = 1'b0;
        address_dataIN    = '0;
        if (guard >= 2000)
            check("write_timeout", 32'(k), 32'(nbeats));
        if (check_ws) begin
            foreach (acc[i]) begin
`ifdef BUS_RAM_WAIT_STATE_EN
                check("accept_cycle", 32'(acc[i]), 32'(1 + 2 * i));
`else
                check("accept_cycle", 32'(acc[i]), 32'(1 + i));
`endif
            end
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int burst, input int stall_beat,
                           input int stall_len, input bit rand_stall, input int abort_after);
        int base       = int'(addr[11:2]);
        int nexp       = (abort_after >= 0) ? abort_after : burst + 1;
        int cycle      = 1;
        int consumed   = 0;
        int stall_left = stall_len;
        int first      = -1;
        int last       = -1;
        int guard      = 0;
        bit done       = 0;
        for (int i = 0; i < nexp; i++)
            exp_q.push_back(ref_mem[base + i]);
        start_txn(addr, burst, 1'b1);
        while (!done && guard < 2000) begin
            guard++;
            if (abort_after >= 0 && consumed == abort_after) begin
                end_transactionIN = 1'b1;
                busyIN            = 1'b1;
                @(posedge clk); #1;
                end_transactionIN = 1'b0;
                busyIN            = 1'b0;
                check("abort_outputs_zero", all_outs(), 32'd0);
                for (int j = 0; j < 2; j++) begin
                    @(posedge clk); #1;
                    check("abort_no_end", all_outs(), 32'd0);
                end
                done = 1;
            end else begin
                if (end_transactionOUT) begin
                    check("end_cycle", 32'(cycle), 32'(last + 1));
                    check("beats_consumed", 32'(consumed), 32'(burst + 1));
                    busyIN = 1'b0;
                    done   = 1;
                end else if (data_validOUT) begin
                    if (first < 0) first = cycle;
                    if (consumed == stall_beat && stall_left > 0) begin
                        busyIN = 1'b1;
                        stall_left--;
                    end else if (rand_stall && $urandom_range(0, 2) == 0) begin
                        busyIN = 1'b1;
                    end else begin
                        busyIN = 1'b0;
                        consumed++;
                        last = cycle;
                    end
                end else begin
                    busyIN = 1'b0;
                end
                if (!done) begin
                    @(posedge clk); #1;
                    cycle++;
                end
            end
        end
        if (!done)
            check("read_timeout", 32'(consumed), 32'(burst + 1));
        check("first_valid_cycle", 32'(first), 32'd2);
    endtask

    task automatic do_error(input logic [31:0] addr, input int burst, input logic rnw);
        start_txn(addr, burst, rnw);
        data_validIN   = !rnw;
        address_dataIN = 32'hBAD0_BAD0;
        byte_enableIN  = 4'hF;
        check("error_c1", {30'd0, errorOUT, end_transactionOUT}, 32'd3);
        @(posedge clk); #1;
        check("error_c2", {30'd0, errorOUT, end_transactionOUT}, 32'd0);
        data_validIN   = 1'b0;
        address_dataIN = '0;
    endtask

    task automatic do_ignored(input logic [31:0] addr, input logic rnw);
        start_txn(addr, 3, rnw);
        for (int j = 0; j < 5; j++) begin
            data_validIN   = !rnw;
            address_dataIN = 32'h5555_AAAA;
            check("ignored_quiet", all_outs(), 32'd0);
            @(posedge clk); #1;
        end
        data_validIN   = 1'b0;
        address_dataIN = '0;
    endtask

    initial begin
        int k;
        int base;
        int burst;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the first 256 words with one maximum-length burst, then read it back
        for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
        do_write(32'h4000_0000, 256, 4'hF, 0, 0, 0);
        do_read(32'h4000_0000, 255, -1, 0, 1, -1);

        wbuf[0] = 32'hDEAD_BEEF;
        do_write(32'h4000_0010, 1, 4'hF, 0, 0, 1);
        do_read(32'h4000_0010, 0, -1, 0, 0, -1);

        wbuf[0] = 32'h1122_3344;
        do_write(32'h4000_0010, 1, 4'b0101, 0, 0, 0);
        check("partial_be_model", ref_mem[4], 32'hDE22_BE44);
        do_read(32'h4000_0010, 0, -1, 0, 0, -1);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        do_write(32'h4000_0100, 4, 4'hF, 0, 0, 1);
        do_read(32'h4000_0100, 3, 1, 2, 0, -1);

        do_ignored(32'h5000_0000, 1'b1);
        do_ignored(32'h5000_0040, 1'b0);

        wbuf[0] = 32'hCAFE_F00D;
        do_write(32'h4000_0FFC, 1, 4'hF, 0, 0, 0);
        do_error(32'h4000_0FFC, 1, 1'b0);
        do_read(32'h4000_0FFC, 0, -1, 0, 0, -1);
        do_error(32'h4000_0F00, 255, 1'b1);

        do_read(32'h4000_0000, 7, -1, 0, 0, 2);
        do_read(32'h4000_0020, 2, -1, 0, 0, -1);

        // Reset in the middle of a write: two beats land, the third does not
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA5A5_0000 + 32'(i);
        start_txn(32'h4000_0200, 3, 1'b0);
        k = 0;
        for (int g = 0; g < 20 && k < 2; g++) begin
            data_validIN   = 1'b1;
            address_dataIN = wbuf[k];
            byte_enableIN  = 4'hF;
            if (!busyOUT) begin
                ref_mem[128 + k] = wbuf[k];
                k++;
            end
            @(posedge clk); #1;
        end
        address_dataIN = wbuf[2];
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async_outputs", all_outs(), 32'd0);
        data_validIN   = 1'b0;
        address_dataIN = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_read(32'h4000_0200, 3, -1, 0, 0, -1);

        for (int it = 0; it < 20; it++) begin
            base  = $urandom_range(0, 240);
            burst = $urandom_range(0, 15);
            for (int i = 0; i <= burst; i++) wbuf[i] = $urandom;
            do_write(32'h4000_0000 + 32'(base * 4), burst + 1, 4'hF, 1, 1, 0);
            do_read(32'h4000_0000 + 32'(base * 4), burst, -1, 0, 1, -1);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bus_ram_slave.md
# bus_ram_slave

Single-ported word RAM exposed as a slave on the system bus driven by the JTAG bus master (`jtag_support`). It decodes transactions in its address window, accepts write bursts with byte enables, and returns read bursts with `busyIN` back-pressure. It sits directly downstream of the JTAG master and consumes the master's `*OUT` bus signals.

## Interface
- `BASE_ADDRESS`, default 32'h4000_0000: byte base of the window; must be aligned to the window size.
- `ADDR_WORDS_LOG2`, default 10: log2 of the RAM depth in 32-bit words (default 1024 words, 4 KiB window).
- `system_clock`  in  1  single clock; all logic on its rising edge.
- `system_reset_n`  in  1  asynchronous, active-low reset.
- `address_dataIN`  in  32  address on the begin cycle, write data on beats.
- `byte_enableIN`  in  4  per-byte write enables; bit i covers bits [8i+7:8i].
- `burst_sizeIN`  in  8  beats − 1, so 0 to 255 gives 1 to 256 beats.
- `read_n_writeIN`  in  1  1 = read, 0 = write; sampled with begin.
- `begin_transactionIN`  in  1  one-cycle start strobe.
- `end_transactionIN`  in  1  master terminates the transaction.
- `data_validIN`  in  1  write beat valid.
- `busyIN`  in  1  master stalls read beats.
- `address_dataOUT`  out  32  read data; 0 when not driving.
- `data_validOUT`  out  1  read beat valid.
- `end_transactionOUT`  out  1  slave-side end of a read or an error.
- `busyOUT`  out  1  slave stalls write beats.
- `errorOUT`  out  1  transaction rejected.

## Operation
- The bus is wired-OR, so every output is 0 whenever the slave is not driving it.
- Reset values: all outputs are 0, the state is IDLE, and the beat counter and index are 0. RAM contents are not reset.
- Select condition: `begin_transactionIN`=1 and `address_dataIN[31:ADDR_WORDS_LOG2+2]` equals the same bits of `BASE_ADDRESS`.
  - Non-selected transactions are ignored completely.
- Word index: `address_dataIN[ADDR_WORDS_LOG2+1:2]`. Bits [1:0] are ignored.
- States are IDLE, WRITE, READ, READ_END and ERROR.
- IDLE:
  - On select, latch the index, `beats = burst_sizeIN+1` and `read_n_writeIN`.
  - If `index + burst_sizeIN > 2^ADDR_WORDS_LOG2 − 1`, go to ERROR. Bursts never wrap.
  - Otherwise go to READ or WRITE.
- ERROR: `errorOUT`=1 and `end_transactionOUT`=1 for exactly one cycle, then IDLE.
- WRITE:
  - A beat is accepted on a cycle with `data_validIN`=1 and `busyOUT`=0.
  - An accepted beat writes the enabled bytes to mem[index], then increments the index and decrements the remaining count.
  - Beats after the count reaches 0 are ignored.
  - `end_transactionIN`=1 returns to IDLE on the next edge, in the same cycle as any beat. A beat in that cycle is still written.
- READ:
  - Data beats are driven with `data_validOUT`=1, full word regardless of byte enables.
  - While `busyIN`=1, the current beat holds: `address_dataOUT` and `data_validOUT` stay stable and the index does not advance.
  - After the last beat is consumed (`data_validOUT`=1, `busyIN`=0), go to READ_END.
- READ_END: `end_transactionOUT`=1 for one cycle, then IDLE.
- `end_transactionIN`=1 during READ aborts the read: outputs go to 0 next cycle, the state goes to IDLE, and no `end_transactionOUT` is issued.
- A `begin_transactionIN` while not in IDLE is ignored.
- Reset asserted mid-transaction immediately forces the reset values. Writes already performed persist.

## Timing
- Cycle 0: begin sampled.
- Write: the first beat can be accepted from cycle 1. `busyOUT`=0 in WRITE, except as described in Configuration.
- Read:
  - First `data_validOUT` at cycle 2 (synchronous RAM, 1-cycle latency).
  - Unstalled beats are back-to-back.
  - `end_transactionOUT` comes 1 cycle after the last consumed beat.
- Error: `errorOUT` and `end_transactionOUT` at cycle 1.
- Max throughput is one word per cycle in each direction.

## Configuration
- `BUS_RAM_WAIT_STATE_EN`:
  - Defined: after every accepted write beat, `busyOUT`=1 for exactly one cycle, so the write rate is 1 word per 2 cycles. A `data_validIN` in that cycle is not accepted and must be held by the master.
  - Undefined: `busyOUT` is constantly 0.

## Test plan
- Single write, then read back:
  - Write 0xDEADBEEF, be=4'hF, to 0x4000_0010.
  - Read the same address with burst 0 -> `data_validOUT` at cycle 2 with 0xDEADBEEF, `end_transactionOUT` at cycle 3.
- Partial byte enable:
  - Write 0x11223344 with be=4'b0101 over 0xDEADBEEF at 0x4000_0010.
  - Read back -> 0xDE22BE44.
- Burst with stall:
  - Write 4 beats 1, 2, 3, 4 from 0x4000_0100.
  - Read with burst 3, holding `busyIN`=1 for 2 cycles on beat 2 -> beats 1, 2, 3, 4 in order, beat 2 held stable, then one `end_transactionOUT`.
- Window and range:
  - Begin at 0x5000_0000 -> no output activity.
  - Begin at 0x4000_0FFC with burst 1 -> `errorOUT` and `end_transactionOUT` for 1 cycle at cycle 1, and RAM unchanged.
- Abort and reset:
  - `end_transactionIN` after the 2nd beat of an 8-beat read -> outputs 0, returns to IDLE.
  - `system_reset_n` low mid-write -> outputs 0 asynchronously, and the next transaction works.
- With `BUS_RAM_WAIT_STATE_EN`:
  - Continuous 4-beat write -> `busyOUT` alternates, beats are accepted on cycles 1, 3, 5 and 7, and readback matches.
